hsv_facelet_vote: RTL
=====================

# hsv_facelet_vote

Downstream consumer of the RGB→HSV converter in the cube-facelet colour path. Accepts one 25-bit HSV sample per `hsv_valid` pulse (`hsv_valid` is wired to the converter's `hsv_done`) and bins each sample into one of six cube colours or "unknown". After a programmable number of samples, it performs a sequential majority vote and emits a single colour code for the facelet. The result feeds the cube-state assembler.

## Interface
Parameters:
- `SAMPLES`, 16: samples voted per facelet; legal range 1..31.
- `MIN_VOTES`, 1: winning count below this yields unknown.
- `V_MIN`, 40: Value below this is dark.
- `S_WHITE_MAX`, 60: Saturation below this is white.
- `H_RO`, 15: red/orange hue boundary.
- `H_OY`, 40: orange/yellow hue boundary.
- `H_YG`, 75: yellow/green hue boundary.
- `H_GB`, 160: green/blue hue boundary.
- `H_BR`, 300: blue/red hue boundary.

Ports:
- `pclk`  in  1  clock; one clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a new facelet.
- `hsv_valid`  in  1  sample strobe.
- `hsv`  in  25  sample fields: [24:16] H (0..359), [15:8] S, [7:0] V.
- `busy`  out  1  high in every state except IDLE.
- `color`  out  3  result code: 0 white, 1 yellow, 2 red, 3 orange, 4 green, 5 blue, 7 unknown; 6 is never produced.
- `color_valid`  out  1  one-cycle result strobe.

## Operation
- Classification is combinational on `hsv` and applied in this order:
  - V < `V_MIN`: dark, counted as unknown (7).
  - H > 359: unknown.
  - S < `S_WHITE_MAX`: white.
  - H < `H_RO` or H ≥ `H_BR`: red.
  - H < `H_OY`: orange.
  - H < `H_YG`: yellow.
  - H < `H_GB`: green.
  - Otherwise: blue.
- Vote storage: seven 5-bit counters (codes 0..5 and 7), plus a 5-bit sample counter and a 3-bit scan index.
- States:
  - **IDLE**: `start` clears all counters and moves to COLLECT. `hsv_valid` is ignored in IDLE, including a `hsv_valid` coincident with `start`.
  - **COLLECT**: each `hsv_valid` increments the counter of its class and the sample counter. When the sample counter reaches `SAMPLES`, move to RESOLVE. A `start` in COLLECT clears all counters and stays in COLLECT; a `hsv_valid` in the same cycle as that `start` is discarded.
  - **RESOLVE**: scans one counter per cycle in code order 0,1,2,3,4,5,7 (7 cycles). The running best is replaced only on a strictly greater count, so ties go to the lowest code. After the 7th entry, if best count < `MIN_VOTES`, the result is 7; otherwise it is the best code. The result is registered into `color` and the state moves to DONE. `start` and `hsv_valid` are ignored in RESOLVE.
  - **DONE**: `color_valid` is high for this one cycle; return to IDLE. `start` in DONE is ignored.
- `color` holds its value until the next result is written.
- Counters cannot overflow because `SAMPLES` ≤ 31.

## Timing
- Reset values: state IDLE, `busy`=0, `color`=7, `color_valid`=0, all counters 0.
- Asserting `rst_n` low at any point, including mid-RESOLVE, aborts the operation immediately. No `color_valid` is produced for the aborted facelet.
- Latency:
  - Let E0 be the edge that accepts the final sample.
  - Edges E1..E7 perform the scan; `color` is updated at E7.
  - `color_valid` is high from E7 to E8.
  - `busy` falls at E8.
- Throughput: one facelet per `SAMPLES` converter results + 8 cycles. `start` is accepted again from the cycle after E8.
- Back-to-back `hsv_valid` on consecutive cycles are all accepted.

## Configuration
- `HSV_VOTE_DARK_REJECT_EN`:
  - Defined: samples with V < `V_MIN` increment no counter, neither a class counter nor the sample counter. The facelet therefore waits for `SAMPLES` non-dark samples.
  - Undefined: dark samples vote unknown (7) and count toward `SAMPLES`.

## Test plan
- Reset: 16 samples of H=0, S=200, V=200 → `color`=2 and `color_valid` high exactly 7 edges after the 16th sample; `busy` low one cycle later.
- Tie and wrap: 8 samples at H=120 plus 8 at H=230 → 4. Separately, 16 samples at H=350 → 2.
- White and unknown: 16 samples at S=20, V=220 → 0. With `MIN_VOTES`=9, 8 samples at H=60 plus 8 at H=25 → 7.
- Restart and reset: `start` after 5 samples of blue, then 16 green → 4. Separately, `rst_n` low during RESOLVE → no `color_valid`, `color`=7, `busy`=0.
- Dark samples, 4 at V=10 plus 16 at H=60:
  - With `HSV_VOTE_DARK_REJECT_EN` defined: → 1 after the 20th sample.
  - Without it: → 1 after the 16th sample, since the first 16 samples are 4 dark plus 12 yellow.

Source files
------------

// File: rtl/hsv_facelet_vote.sv
// Bins HSV samples into cube colours and majority-votes SAMPLES of them into one facelet colour.
// Optional build macro HSV_VOTE_DARK_REJECT_EN: dark samples are dropped instead of voting unknown.
module hsv_facelet_vote #(
    parameter int SAMPLES     = 16,
    parameter int MIN_VOTES   = 1,
    parameter int V_MIN       = 40,
    parameter int S_WHITE_MAX = 60,
    parameter int H_RO        = 15,
    parameter int H_OY        = 40,
    parameter int H_YG        = 75,
    parameter int H_GB        = 160,
    parameter int H_BR        = 300
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hsv_valid,
    input  logic [24:0] hsv,
    output logic        busy,
    output logic [2:0]  color,
    output logic        color_valid
);

    typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, DONE} state_t;

    localparam logic [4:0] SAMPLES_L   = 5'(SAMPLES);
    localparam logic [5:0] MIN_VOTES_L = 6'(MIN_VOTES);
    localparam logic [7:0] V_MIN_L     = 8'(V_MIN);
    localparam logic [7:0] S_WHITE_L   = 8'(S_WHITE_MAX);
    localparam logic [8:0] H_RO_L      = 9'(H_RO);
    localparam logic [8:0] H_OY_L      = 9'(H_OY);
    localparam logic [8:0] H_YG_L      = 9'(H_YG);
    localparam logic [8:0] H_GB_L      = 9'(H_GB);
    localparam logic [8:0] H_BR_L      = 9'(H_BR);
    localparam logic [8:0] H_MAX_L     = 9'd359;

    function automatic logic [2:0] classify(input logic [24:0] s);
        logic [8:0] h;
        logic [2:0] code;
        h = s[24:16];
        if (s[7:0] < V_MIN_L)                code = 3'd7;
        else if (h > H_MAX_L)                code = 3'd7;
        else if (s[15:8] < S_WHITE_L)        code = 3'd0;
        else if (h < H_RO_L || h >= H_BR_L)  code = 3'd2;
        else if (h < H_OY_L)                 code = 3'd3;
        else if (h < H_YG_L)                 code = 3'd1;
        else if (h < H_GB_L)                 code = 3'd4;
        else                                 code = 3'd5;
        return code;
    endfunction

    // Code 7 lives in counter slot 6 so the seven counters are contiguous.
    function automatic logic [2:0] code_to_idx(input logic [2:0] code);
        return (code == 3'd7) ? 3'd6 : code;
    endfunction

    state_t     state_r, state_s;
    logic [4:0] cnt_r [0:6];
    logic [4:0] sample_r;
    logic [2:0] idx_r;
    logic [4:0] best_cnt_r;
    logic [2:0] best_code_r;
    logic [2:0] color_r;
    logic       color_valid_r;
    logic       busy_r;

    logic       dark_s, countable_s, clear_s, accept_s, scan_s, finish_s;
    logic [2:0] class_s, acc_idx_s, scan_code_s, new_code_s, result_s;
    logic [4:0] cand_s, new_cnt_s;

    assign class_s   = classify(hsv);
    assign acc_idx_s = code_to_idx(class_s);
    assign dark_s    = (hsv[7:0] < V_MIN_L);
`ifdef HSV_VOTE_DARK_REJECT_EN
    assign countable_s = ~dark_s;
`else
    assign countable_s = 1'b1;
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s  = state_r;
        clear_s  = 1'b0;
        accept_s = 1'b0;
        scan_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    clear_s = 1'b1;
                    state_s = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (start) begin
                    clear_s = 1'b1;
                end else if (hsv_valid && countable_s) begin
                    accept_s = 1'b1;
                    if (sample_r + 5'd1 == SAMPLES_L) state_s = RESOLVE;
                    else                              state_s = COLLECT;
                end else begin
                    state_s = COLLECT;
                end
            end
            RESOLVE: begin
                scan_s = 1'b1;
                if (idx_r == 3'd6) begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s = RESOLVE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Running-best comparison for the counter under the scan index; ties keep the lower code.
    always_comb begin
        cand_s      = cnt_r[idx_r];
        scan_code_s = (idx_r == 3'd6) ? 3'd7 : idx_r;
        if (cand_s > best_cnt_r) begin
            new_cnt_s  = cand_s;
            new_code_s = scan_code_s;
        end else begin
            new_cnt_s  = best_cnt_r;
            new_code_s = best_code_r;
        end
        if ({1'b0, new_cnt_s} < MIN_VOTES_L) result_s = 3'd7;
        else                                 result_s = new_code_s;
    end

    // State register and status outputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            color_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            busy_r        <= (state_s != IDLE);
            color_valid_r <= finish_s;
        end
    end

    // Vote and sample counters.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) cnt_r[i] <= 5'd0;
            sample_r <= 5'd0;
        end else if (clear_s) begin
            for (int i = 0; i < 7; i++) cnt_r[i] <= 5'd0;
            sample_r <= 5'd0;
        end else if (accept_s) begin
            cnt_r[acc_idx_s] <= cnt_r[acc_idx_s] + 5'd1;
            sample_r         <= sample_r + 5'd1;
        end else begin
            sample_r <= sample_r;
        end
    end

    // Scan pointer, running best and the result register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= 3'd0;
            best_cnt_r  <= 5'd0;
            best_code_r <= 3'd0;
            color_r     <= 3'd7;
        end else if (scan_s) begin
            idx_r       <= idx_r + 3'd1;
            best_cnt_r  <= new_cnt_s;
            best_code_r <= new_code_s;
            if (finish_s) color_r <= result_s;
            else          color_r <= color_r;
        end else begin
            idx_r       <= 3'd0;
            best_cnt_r  <= 5'd0;
            best_code_r <= 3'd0;
        end
    end

    assign busy        = busy_r;
    assign color       = color_r;
    assign color_valid = color_valid_r;

endmodule
